eeprom_arb: RTL and testbench

Two-client arbiter and sequencer in front of the single-byte I2C EEPROM controller. It accepts byte read/write requests from two independent clients and grants the controller round-robin. It drives the controller's request/address/data strobes, tracks the controller's `ready` through each transaction, and returns read data to the owning client. It enforces the EEPROM internal write-cycle time (tWR) after every write and flags a hung transaction with a timeout.

---
 rtl/eeprom_arb_pkg.sv | 18 +
 rtl/eeprom_arb_timer.sv | 34 +++
 rtl/eeprom_arb.sv | 215 +++++++++++++++++++++
 tb/tb_eeprom_arb.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eeprom_arb_pkg.sv
// Shared state encodings and default timing constants for the two-client EEPROM arbiter.
package eeprom_arb_pkg;

    localparam logic [4:0] ST_IDLE      = 5'b00001;
    localparam logic [4:0] ST_ISSUE     = 5'b00010;
    localparam logic [4:0] ST_WAIT_BUSY = 5'b00100;
    localparam logic [4:0] ST_WAIT_DONE = 5'b01000;
    localparam logic [4:0] ST_TWR       = 5'b10000;

    // 5 ms write-cycle guard and 40 ms hang limit at a 50 MHz clock.
    localparam int TWR_CYCLES_DEFAULT     = 250000;
    localparam int TIMEOUT_CYCLES_DEFAULT = 2000000;

    function automatic int max_cycles(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/eeprom_arb_timer.sv
// Clearable up-counter that saturates at a runtime-selected terminal count.
module eeprom_arb_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired_o = (cnt_q == limit_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/eeprom_arb.sv
// Round-robin arbiter and sequencer sharing one byte-wide I2C EEPROM controller between two
// clients, with a post-write tWR guard and a per-transaction hang timeout.
module eeprom_arb
    import eeprom_arb_pkg::*;
#(
    parameter int TWR_CYCLES     = TWR_CYCLES_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c0_req,
    input  logic       c1_req,
    input  logic       c0_wr,
    input  logic       c1_wr,
    input  logic [7:0] c0_addr,
    input  logic [7:0] c1_addr,
    input  logic [7:0] c0_wdata,
    input  logic [7:0] c1_wdata,
    output logic       c0_gnt,
    output logic       c1_gnt,
    output logic       c0_done,
    output logic       c1_done,
    output logic       c0_err,
    output logic       c1_err,
    output logic [7:0] c0_rdata,
    output logic [7:0] c1_rdata,
    output logic       c0_rdata_vld,
    output logic       c1_rdata_vld,
    output logic       ee_wr_req,
    output logic       ee_rd_req,
    output logic [7:0] ee_reg_addr,
    output logic       ee_reg_addr_vld,
    output logic [7:0] ee_wr_data,
    output logic       ee_wr_data_vld,
    input  logic [7:0] ee_rd_data,
    input  logic       ee_rd_data_vld,
    input  logic       ee_ready
);

    localparam int            MAX_CYCLES   = max_cycles(TWR_CYCLES, TIMEOUT_CYCLES);
    localparam int            CW           = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] TWR_LAST     = CW'(TWR_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [4:0]    state_q, state_d;
    logic          last_owner_q, last_owner_d;
    logic          owner_q, owner_d;
    logic          wr_q, wr_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          wr_req_q, wr_req_d;
    logic          rd_req_q, rd_req_d;
    logic          addr_vld_q, addr_vld_d;
    logic          data_vld_q, data_vld_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    done_q, done_d;
    logic [1:0]    err_q, err_d;
    logic [1:0]    rvld_q, rvld_d;
    logic [7:0]    rdata0_q, rdata0_d;
    logic [7:0]    rdata1_q, rdata1_d;
    logic          sel;
    logic          tmr_en;
    logic          tmr_clear;
    logic          tmr_expired;
    logic [CW-1:0] tmr_limit;

    // The timeout window spans ISSUE..WAIT_DONE, so only entries into other states restart the count.
    assign tmr_clear = (state_d != state_q) && (state_d != ST_WAIT_BUSY) && (state_d != ST_WAIT_DONE);
    assign tmr_limit = (state_q == ST_TWR) ? TWR_LAST : TIMEOUT_LAST;

    eeprom_arb_timer #(
        .W (CW)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (tmr_clear),
        .en_i      (tmr_en),
        .limit_i   (tmr_limit),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        owner_d      = owner_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_req_d     = 1'b0;
        rd_req_d     = 1'b0;
        addr_vld_d   = 1'b0;
        data_vld_d   = 1'b0;
        gnt_d        = 2'b00;
        done_d       = 2'b00;
        err_d        = 2'b00;
        rvld_d       = 2'b00;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        sel          = 1'b0;
        tmr_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((c0_req || c1_req) && ee_ready) begin
                    sel        = (c0_req && c1_req) ? ~last_owner_q : c1_req;
                    owner_d    = sel;
                    wr_d       = sel ? c1_wr : c0_wr;
                    addr_d     = sel ? c1_addr : c0_addr;
                    if (wr_d) begin
                        wdata_d = sel ? c1_wdata : c0_wdata;
                    end
                    gnt_d[sel] = 1'b1;
                    wr_req_d   = wr_d;
                    rd_req_d   = ~wr_d;
                    addr_vld_d = 1'b1;
                    data_vld_d = wr_d;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE, ST_WAIT_BUSY, ST_WAIT_DONE: begin
                tmr_en = 1'b1;
                if (state_q == ST_ISSUE) begin
                    last_owner_d = owner_q;
                end
                if ((state_q == ST_WAIT_DONE) && ee_rd_data_vld) begin
                    rvld_d[owner_q] = 1'b1;
                    if (owner_q) begin
                        rdata1_d = ee_rd_data;
                    end else begin
                        rdata0_d = ee_rd_data;
                    end
                end
                // A genuine completion wins over a timeout landing on the same cycle.
                if ((state_q == ST_WAIT_DONE) && ee_ready) begin
                    done_d[owner_q] = 1'b1;
                    state_d         = wr_q ? ST_TWR : ST_IDLE;
                end else if (tmr_expired) begin
                    done_d[owner_q] = 1'b1;
                    err_d[owner_q]  = 1'b1;
                    state_d         = ST_IDLE;
                end else if (state_q == ST_ISSUE) begin
                    state_d = ST_WAIT_BUSY;
                end else if ((state_q == ST_WAIT_BUSY) && !ee_ready) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_TWR: begin
                tmr_en = 1'b1;
                if (tmr_expired) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // last_owner resets to client 1 so client 0 wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wr_req_q     <= 1'b0;
            rd_req_q     <= 1'b0;
            addr_vld_q   <= 1'b0;
            data_vld_q   <= 1'b0;
            gnt_q        <= '0;
            done_q       <= '0;
            err_q        <= '0;
            rvld_q       <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            owner_q      <= owner_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wr_req_q     <= wr_req_d;
            rd_req_q     <= rd_req_d;
            addr_vld_q   <= addr_vld_d;
            data_vld_q   <= data_vld_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rvld_q       <= rvld_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign c0_gnt          = gnt_q[0];
    assign c1_gnt          = gnt_q[1];
    assign c0_done         = done_q[0];
    assign c1_done         = done_q[1];
    assign c0_err          = err_q[0];
    assign c1_err          = err_q[1];
    assign c0_rdata        = rdata0_q;
    assign c1_rdata        = rdata1_q;
    assign c0_rdata_vld    = rvld_q[0];
    assign c1_rdata_vld    = rvld_q[1];
    assign ee_wr_req       = wr_req_q;
    assign ee_rd_req       = rd_req_q;
    assign ee_reg_addr     = addr_q;
    assign ee_reg_addr_vld = addr_vld_q;
    assign ee_wr_data      = wdata_q;
    assign ee_wr_data_vld  = data_vld_q;

endmodule

// File: tb/tb_eeprom_arb.sv
// Directed bench for eeprom_arb: a behavioural controller model plus one task per scenario.
module tb_eeprom_arb;

    localparam int TWR = 20;
    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       c0_req = 1'b0, c1_req = 1'b0, c0_wr = 1'b0, c1_wr = 1'b0;
    logic [7:0] c0_addr = '0, c1_addr = '0, c0_wdata = '0, c1_wdata = '0;
    logic       c0_gnt, c1_gnt, c0_done, c1_done, c0_err, c1_err;
    logic [7:0] c0_rdata, c1_rdata;
    logic       c0_rdata_vld, c1_rdata_vld;
    logic       ee_wr_req, ee_rd_req, ee_reg_addr_vld, ee_wr_data_vld;
    logic [7:0] ee_reg_addr, ee_wr_data;
    logic [7:0] ee_rd_data = '0;
    logic       ee_rd_data_vld = 1'b0;
    logic       ee_ready = 1'b1;

    int   nChecks = 0;
    int   nFails = 0;
    int   cyc = 0;
    logic modelHang = 1'b0;
    logic modelRead = 1'b0;
    logic [7:0] modelData = '0;
    int   modelCnt = 0;

    eeprom_arb #(
        .TWR_CYCLES     (TWR),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .c0_req          (c0_req),
        .c1_req          (c1_req),
        .c0_wr           (c0_wr),
        .c1_wr           (c1_wr),
        .c0_addr         (c0_addr),
        .c1_addr         (c1_addr),
        .c0_wdata        (c0_wdata),
        .c1_wdata        (c1_wdata),
        .c0_gnt          (c0_gnt),
        .c1_gnt          (c1_gnt),
        .c0_done         (c0_done),
        .c1_done         (c1_done),
        .c0_err          (c0_err),
        .c1_err          (c1_err),
        .c0_rdata        (c0_rdata),
        .c1_rdata        (c1_rdata),
        .c0_rdata_vld    (c0_rdata_vld),
        .c1_rdata_vld    (c1_rdata_vld),
        .ee_wr_req       (ee_wr_req),
        .ee_rd_req       (ee_rd_req),
        .ee_reg_addr     (ee_reg_addr),
        .ee_reg_addr_vld (ee_reg_addr_vld),
        .ee_wr_data      (ee_wr_data),
        .ee_wr_data_vld  (ee_wr_data_vld),
        .ee_rd_data      (ee_rd_data),
        .ee_rd_data_vld  (ee_rd_data_vld),
        .ee_ready        (ee_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: ready drops 2 cycles after a request strobe, stays low 30 cycles, and a
    // read returns its byte in the last busy cycle.
    always @(posedge clk) begin
        if (rst) begin
            ee_ready       <= 1'b1;
            ee_rd_data_vld <= 1'b0;
            modelCnt       <= 0;
        end else begin
            ee_rd_data_vld <= 1'b0;
            if (modelCnt == 0) begin
                if ((ee_wr_req || ee_rd_req) && !modelHang) begin
                    modelCnt  <= 1;
                    modelRead <= ee_rd_req;
                end
            end else if (modelCnt == 31) begin
                ee_ready <= 1'b1;
                modelCnt <= 0;
            end else begin
                if (modelCnt == 1) ee_ready <= 1'b0;
                if (modelCnt == 30 && modelRead) begin
                    ee_rd_data_vld <= 1'b1;
                    ee_rd_data     <= modelData;
                end
                modelCnt <= modelCnt + 1;
            end
        end
    end

    function automatic logic [43:0] allOutputs();
        return {c0_gnt, c1_gnt, c0_done, c1_done, c0_err, c1_err, c0_rdata, c1_rdata,
                c0_rdata_vld, c1_rdata_vld, ee_wr_req, ee_rd_req, ee_reg_addr,
                ee_reg_addr_vld, ee_wr_data, ee_wr_data_vld};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        nChecks++;
        if (allOutputs() !== 44'h0) begin
            nFails++;
            $display("[TB] FAIL reset_outputs: got %h, required 0", allOutputs());
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        nChecks++;
        if (allOutputs() !== 44'h0) begin
            nFails++;
            $display("[TB] FAIL idle_outputs: got %h, required 0", allOutputs());
        end
    endtask

    task automatic test_single_write();
        int g;
        bit found;
        c0_req = 1'b1; c0_wr = 1'b1; c0_addr = 8'h12; c0_wdata = 8'hA5;
        @(negedge clk);
        g = cyc;
        nChecks++;
        if ({c0_gnt, c1_gnt, ee_wr_req, ee_rd_req, ee_reg_addr_vld, ee_wr_data_vld} !== 6'b101011) begin
            nFails++;
            $display("[TB] FAIL wr_issue_strobes: got %b, required 101011",
                     {c0_gnt, c1_gnt, ee_wr_req, ee_rd_req, ee_reg_addr_vld, ee_wr_data_vld});
        end
        nChecks++;
        if ({ee_reg_addr, ee_wr_data} !== 16'h12A5) begin
            nFails++;
            $display("[TB] FAIL wr_issue_addr_data: got %h, required 12a5", {ee_reg_addr, ee_wr_data});
        end
        c0_req = 1'b0;
        @(negedge clk);
        nChecks++;
        if ({c0_gnt, ee_wr_req, ee_wr_data_vld} !== 3'b000) begin
            nFails++;
            $display("[TB] FAIL wr_gnt_pulse: got %b, required 000", {c0_gnt, ee_wr_req, ee_wr_data_vld});
        end
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (c0_done) found = 1'b1;
        end
        nChecks++;
        if (!found || (cyc - g) != 33 || c0_err !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL wr_done: found %0d offset %0d err %b, required found 1 offset 33 err 0",
                     found, cyc - g, c0_err);
        end
        repeat (TWR + 5) @(negedge clk);
    endtask

    task automatic test_single_read();
        int eeVldCyc = -10;
        int vldCyc = 0;
        bit found = 1'b0;
        bit c0Seen = 1'b0;
        logic [7:0] rd = '0;
        modelData = 8'h5C;
        c1_req = 1'b1; c1_wr = 1'b0; c1_addr = 8'h34;
        @(negedge clk);
        nChecks++;
        if ({c1_gnt, c0_gnt, ee_rd_req, ee_wr_req, ee_wr_data_vld, ee_reg_addr} !== {5'b10100, 8'h34}) begin
            nFails++;
            $display("[TB] FAIL rd_issue: got %b, required 1010000110100",
                     {c1_gnt, c0_gnt, ee_rd_req, ee_wr_req, ee_wr_data_vld, ee_reg_addr});
        end
        c1_req = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (ee_rd_data_vld) eeVldCyc = cyc;
            if (c0_rdata_vld) c0Seen = 1'b1;
            if (c1_rdata_vld) begin
                found  = 1'b1;
                vldCyc = cyc;
                rd     = c1_rdata;
            end
        end
        nChecks++;
        if (!found || vldCyc != eeVldCyc + 1) begin
            nFails++;
            $display("[TB] FAIL rd_vld_latency: found %0d lag %0d, required found 1 lag 1", found, vldCyc - eeVldCyc);
        end
        nChecks++;
        if (rd !== 8'h5C || c0Seen) begin
            nFails++;
            $display("[TB] FAIL rd_data: got %h c0_vld_seen %0d, required 5c c0_vld_seen 0", rd, c0Seen);
        end
        @(negedge clk);
        nChecks++;
        if ({c1_done, c1_rdata_vld, c1_err} !== 3'b100) begin
            nFails++;
            $display("[TB] FAIL rd_done: got %b, required 100", {c1_done, c1_rdata_vld, c1_err});
        end
        repeat (5) @(negedge clk);
        nChecks++;
        if (c1_rdata !== 8'h5C) begin
            nFails++;
            $display("[TB] FAIL rd_hold: got %h, required 5c", c1_rdata);
        end
    endtask

    task automatic test_contention();
        bit found;
        bit who;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        modelData = 8'h3C;
        c0_req = 1'b1; c0_wr = 1'b0; c0_addr = 8'h01;
        c1_req = 1'b1; c1_wr = 1'b0; c1_addr = 8'h02;
        for (int k = 0; k < 4; k++) begin
            found = 1'b0;
            who   = 1'b0;
            for (int i = 0; i < 100 && !found; i++) begin
                @(negedge clk);
                if (c0_gnt ^ c1_gnt) begin
                    found = 1'b1;
                    who   = c1_gnt;
                end
            end
            nChecks++;
            if (!found || who != k[0]) begin
                nFails++;
                $display("[TB] FAIL contention_order_%0d: found %0d owner %0d, required owner %0d", k, found, who, k[0]);
            end
            if (k == 3) begin
                c0_req = 1'b0;
                c1_req = 1'b0;
            end
            @(negedge clk);
            nChecks++;
            if ({c0_gnt, c1_gnt} !== 2'b00) begin
                nFails++;
                $display("[TB] FAIL contention_pulse_%0d: got %b, required 00", k, {c0_gnt, c1_gnt});
            end
        end
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (c1_done) found = 1'b1;
        end
        nChecks++;
        if (!found || c1_rdata !== 8'h3C) begin
            nFails++;
            $display("[TB] FAIL contention_last_done: found %0d rdata %h, required 1 3c", found, c1_rdata);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        int g;
        bit found = 1'b0;
        modelHang = 1'b1;
        c0_req = 1'b1; c0_wr = 1'b1; c0_addr = 8'h56; c0_wdata = 8'h99;
        @(negedge clk);
        g = cyc;
        nChecks++;
        if (c0_gnt !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL tmo_gnt: got %b, required 1", c0_gnt);
        end
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (c0_done || c0_err) found = 1'b1;
        end
        nChecks++;
        if (!found || (cyc - g) != TMO || {c0_done, c0_err, c1_done} !== 3'b110) begin
            nFails++;
            $display("[TB] FAIL tmo_done_err: found %0d offset %0d done/err/c1done %b, required offset %0d 110",
                     found, cyc - g, {c0_done, c0_err, c1_done}, TMO);
        end
        modelHang = 1'b0;
        @(negedge clk);
        nChecks++;
        if (c0_gnt !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL tmo_no_twr: regrant got %b, required 1", c0_gnt);
        end
        c0_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (c0_done) found = 1'b1;
        end
        nChecks++;
        if (!found || c0_err !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL tmo_recovery: found %0d err %b, required 1 0", found, c0_err);
        end
        repeat (TWR + 5) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        bit found = 1'b0;
        modelData = 8'hE1;
        c0_req = 1'b1; c0_wr = 1'b0; c0_addr = 8'h78;
        @(negedge clk);
        c0_req = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        nChecks++;
        if (allOutputs() !== 44'h0) begin
            nFails++;
            $display("[TB] FAIL midreset_outputs: got %h, required 0", allOutputs());
        end
        rst = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (c0_done || c1_done || c0_rdata_vld || c1_rdata_vld) seen = 1'b1;
        end
        nChecks++;
        if (seen) begin
            nFails++;
            $display("[TB] FAIL midreset_no_done: got 1, required 0");
        end
        c0_req = 1'b1; c1_req = 1'b1; c0_wr = 1'b0; c1_wr = 1'b0;
        @(negedge clk);
        nChecks++;
        if ({c0_gnt, c1_gnt} !== 2'b10) begin
            nFails++;
            $display("[TB] FAIL midreset_first_gnt: got %b, required 10", {c0_gnt, c1_gnt});
        end
        c0_req = 1'b0; c1_req = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (c0_done) found = 1'b1;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write_then_read();
        int d = 0;
        bit found = 1'b0;
        modelData = 8'h77;
        c0_req = 1'b1; c0_wr = 1'b1; c0_addr = 8'h9A; c0_wdata = 8'h42;
        @(negedge clk);
        c0_req = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (c0_done) begin
                found = 1'b1;
                d = cyc;
            end
        end
        c1_req = 1'b1; c1_wr = 1'b0; c1_addr = 8'hBC;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (c1_gnt) found = 1'b1;
        end
        nChecks++;
        if (!found || (cyc - d) != TWR + 1) begin
            nFails++;
            $display("[TB] FAIL twr_blocks_gnt: found %0d gap %0d, required gap %0d", found, cyc - d, TWR + 1);
        end
        c1_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (c1_rdata_vld) found = 1'b1;
        end
        nChecks++;
        if (!found || c1_rdata !== 8'h77) begin
            nFails++;
            $display("[TB] FAIL twr_read_data: found %0d rdata %h, required 1 77", found, c1_rdata);
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        $display("[TB] starting eeprom_arb bench");
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_timeout();
        test_reset_mid();
        test_write_then_read();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
